dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl_pkg.sv | 29 ++
 rtl/dcache_ctrl_latency_counter.sv | 36 +++
 rtl/dcache_ctrl.sv | 139 +++++++++++++
 tb/tb_dcache_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the data-cache sequencing controller.
// Provides the FSM state type, the byte-address field layout of the
// 2-way / 512-set / 64-bit-block cache, and the default memory latency.
package dcache_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StSettle,
        StWrite
    } state_e;

    // Byte-address fields: tag | index (512 sets) | offset within 8-byte block.
    localparam int unsigned TagMsb         = 31;
    localparam int unsigned TagLsb         = 12;
    localparam int unsigned IndexMsb       = 11;
    localparam int unsigned IndexLsb       = 3;
    localparam int unsigned OffsetMsb      = 2;
    localparam int unsigned BlockAlignBits = OffsetMsb + 1;

    localparam int unsigned DefaultMemLatency = 8;

    // Clear the block offset so memory returns the whole 64-bit line.
    function automatic logic [31:0] block_align(input logic [31:0] a);
        return {a[TagMsb:TagLsb], a[IndexMsb:IndexLsb], {BlockAlignBits{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_ctrl_latency_counter.sv
// Loadable down-counter used to time main-memory accesses.
// Ports: clk, rst (sync, active-high), load/load_val (load has priority),
//        en (decrement, saturating at zero), zero (count == 0).
module latency_counter #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 en,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dcache_ctrl.sv
// Sequencing controller for the 2-way set-associative data cache.
// Turns MEM-stage load/store requests plus the cache's registered hit/miss
// result into pipeline stalls, block-read refills and write-through stores.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_req, wr_req      load / store in MEM stage (sampled only when idle)
//   addr, wdata         byte address and store data
//   hit_miss            cache lookup result, valid in the cycle after rd_req
//   stall               pipeline freeze (Mealy in the lookup cycle)
//   countdone           one-cycle refill-complete pulse to the cache
//   mem_rd, mem_wr      memory block-read / word-write strobes
//   mem_addr, mem_wdata memory address and write-through data
//   busy                controller not idle
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = DefaultMemLatency,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  hit_miss,
    output logic                  stall,
    output logic                  countdone,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] LoadVal = CNT_WIDTH'(MEM_LATENCY - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  cnt_load, cnt_en, cnt_zero;

    latency_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_latency_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(LoadVal),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        wdata_d    = wdata_q;
        stall      = 1'b0;
        countdone  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        // Address is held at its last driven value when not accessing memory.
        mem_addr   = mem_addr_q;

        unique case (state_q)
            StIdle: begin
                // A store wins over a simultaneous load; the load is dropped.
                if (wr_req) begin
                    req_addr_d = addr;
                    wdata_d    = wdata;
                    cnt_load   = 1'b1;
                    state_d    = StWrite;
                end else if (rd_req) begin
                    req_addr_d = addr;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                if (hit_miss) begin
                    state_d = StIdle;
                end else begin
                    stall    = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = StRefill;
                end
            end
            StRefill: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = block_align(req_addr_q);
                cnt_en   = 1'b1;
                if (cnt_zero) begin
                    countdone = 1'b1;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                // One extra stall so the cache's registered state shows the new line.
                stall   = 1'b1;
                state_d = StIdle;
            end
            StWrite: begin
                stall    = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = req_addr_q;
                cnt_en   = 1'b1;
                if (cnt_zero) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr;
        end
    end

    // Store data only changes on entry to a write, so the latch doubles as mem_wdata.
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst, rd_req, wr_req, hit_miss;
    logic [31:0] addr, wdata;
    logic        sel; // 0: MEM_LATENCY=8 instance, 1: MEM_LATENCY=1 instance

    always #5 clk = ~clk;

    logic        rd0, wr0, rd1, wr1;
    logic        st0, cd0, mr0, mw0, bz0, st1, cd1, mr1, mw1, bz1;
    logic [31:0] ma0, md0, ma1, md1;

    assign rd0 = rd_req & ~sel;
    assign wr0 = wr_req & ~sel;
    assign rd1 = rd_req & sel;
    assign wr1 = wr_req & sel;

    dcache_ctrl #(
        .MEM_LATENCY(8),
        .CNT_WIDTH  (4),
        .ADDR_WIDTH (32)
    ) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd0),
        .wr_req   (wr0),
        .addr     (addr),
        .wdata    (wdata),
        .hit_miss (hit_miss),
        .stall    (st0),
        .countdone(cd0),
        .mem_rd   (mr0),
        .mem_wr   (mw0),
        .mem_addr (ma0),
        .mem_wdata(md0),
        .busy     (bz0)
    );

    dcache_ctrl #(
        .MEM_LATENCY(1),
        .CNT_WIDTH  (4),
        .ADDR_WIDTH (32)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd1),
        .wr_req   (wr1),
        .addr     (addr),
        .wdata    (wdata),
        .hit_miss (hit_miss),
        .stall    (st1),
        .countdone(cd1),
        .mem_rd   (mr1),
        .mem_wr   (mw1),
        .mem_addr (ma1),
        .mem_wdata(md1),
        .busy     (bz1)
    );

    typedef struct {
        logic        stall;
        logic        mem_rd;
        logic        mem_wr;
        logic        countdone;
        logic        busy;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_addr[2];
    logic [31:0] last_wdata[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t, lat=%0d)", tag, got, want, $time,
                     sel ? 1 : 8);
        end
    endtask

    // Scoreboard: one expected output record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",     32'(sel ? st1 : st0), 32'(e.stall));
            check("mem_rd",    32'(sel ? mr1 : mr0), 32'(e.mem_rd));
            check("mem_wr",    32'(sel ? mw1 : mw0), 32'(e.mem_wr));
            check("countdone", 32'(sel ? cd1 : cd0), 32'(e.countdone));
            check("busy",      32'(sel ? bz1 : bz0), 32'(e.busy));
            check("mem_addr",  sel ? ma1 : ma0, e.mem_addr);
            check("mem_wdata", sel ? md1 : md0, e.mem_wdata);
        end
    end

    task automatic cyc(input logic st, input logic rd, input logic wr, input logic cd,
                       input logic bz, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.stall     = st;
        e.mem_rd    = rd;
        e.mem_wr    = wr;
        e.countdone = cd;
        e.busy      = bz;
        e.mem_addr  = a;
        e.mem_wdata = wd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_addr[sel], last_wdata[sel]);
    endtask

    // Read access; on a miss, spurious requests are held high to prove they are ignored.
    task automatic do_read(input logic [31:0] a, input logic hit);
        int          lat;
        logic [31:0] ba;
        lat    = sel ? 1 : 8;
        ba     = {a[31:3], 3'b000};
        rd_req = 1'b1;
        addr   = a;
        idle_cycle();
        rd_req   = 1'b0;
        addr     = 32'h0BAD_F00C;
        hit_miss = hit;
        cyc(~hit, 1'b0, 1'b0, 1'b0, 1'b1, last_addr[sel], last_wdata[sel]);
        if (!hit) begin
            rd_req = 1'b1;
            wr_req = 1'b1;
            last_addr[sel] = ba;
            for (int i = 0; i < lat; i++) begin
                cyc(1'b1, 1'b1, 1'b0, (i == lat - 1), 1'b1, ba, last_wdata[sel]);
            end
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ba, last_wdata[sel]);
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
        hit_miss = 1'b1;
        idle_cycle();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic both);
        int lat;
        lat    = sel ? 1 : 8;
        wr_req = 1'b1;
        rd_req = both;
        addr   = a;
        wdata  = d;
        idle_cycle();
        wr_req = 1'b0;
        rd_req = 1'b0;
        addr   = 32'h0BAD_F00C;
        wdata  = 32'h5555_AAAA;
        last_addr[sel]  = a;
        last_wdata[sel] = d;
        for (int i = 0; i < lat; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, d);
        end
        idle_cycle();
    endtask

    task automatic reset_during_refill();
        logic [31:0] ba;
        ba     = 32'h0000_4010;
        rd_req = 1'b1;
        addr   = 32'h0000_4014;
        idle_cycle();
        rd_req   = 1'b0;
        hit_miss = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, last_addr[sel], last_wdata[sel]);
        // Counter runs 7,6,5,4,3; reset is sampled at the end of the count-3 cycle.
        for (int i = 0; i < 5; i++) begin
            if (i == 4) rst = 1'b1;
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ba, last_wdata[sel]);
        end
        rst      = 1'b0;
        hit_miss = 1'b1;
        for (int i = 0; i < 2; i++) begin
            last_addr[i]  = '0;
            last_wdata[i] = '0;
        end
        // Covers the cycles where the aborted miss would have pulsed countdone.
        for (int i = 0; i < 5; i++) idle_cycle();
    endtask

    initial begin
        sel      = 1'b0;
        rst      = 1'b1;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        hit_miss = 1'b1;
        addr     = '0;
        wdata    = '0;
        for (int i = 0; i < 2; i++) begin
            last_addr[i]  = '0;
            last_wdata[i] = '0;
        end
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        idle_cycle();

        do_read(32'h0000_1008, 1'b1);
        do_read(32'h0000_2004, 1'b0);
        do_write(32'h0000_300C, 32'hDEAD_BEEF, 1'b0);
        do_write(32'h0000_5004, 32'h1234_5678, 1'b1);
        do_read(32'h0000_2004, 1'b1);
        reset_during_refill();
        do_read(32'h0000_6ABC, 1'b0);

        sel = 1'b1;
        idle_cycle();
        do_read(32'h0000_2004, 1'b0);
        do_read(32'h0000_1008, 1'b1);
        do_write(32'h0000_300C, 32'hDEAD_BEEF, 1'b0);
        do_write(32'h0000_7000, 32'hCAFE_0001, 1'b1);
        do_read(32'hFFFF_FFFF, 1'b0);

        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
